// File: rtl/snn_inference_sequencer.sv
// Sequences one SNN inference: streams the stored image to the core, pulses start, waits for done or watchdog.
// Latency: request edge -> LOAD next cycle; IMAGE_SIZE pixel beats; CORE_START one cycle after the last beat.
// Backpressure: pixel stream stalls (VALID, index, pixel held) while CORE_PIXEL_READY is low.
//
// Ports:
//   ACLK / ARESETN          clock, synchronous active-low reset
//   NEW_IMAGE               level from register file; each rising edge requests one inference
//   PIX_ADDR / PIX_DATA     combinational read port into the register-file image array
//   CORE_PIXEL*             valid/ready pixel stream to the core (pixel + index)
//   CORE_START / CORE_DONE  one-cycle start pulse out, one-cycle completion pulse in
//   CORE_DIGIT              core result, sampled when CORE_DONE is high in RUN
//   COPROCESSOR_RDY         result valid and no inference in progress
//   INFERED_DIGIT / TIMEOUT last result (8'hFF on watchdog abort) and abort flag
//   BUSY                    sequencer not idle
module snn_inference_sequencer #(
    parameter int IMAGE_SIZE      = 256,
    parameter int IMAGE_SIZE_BITS = $clog2(IMAGE_SIZE),
    parameter int PIXEL_BITS      = 8,
    parameter int TIMEOUT_CYCLES  = 65536,
    parameter int TIMER_BITS      = $clog2(TIMEOUT_CYCLES)
) (
    input  logic                       ACLK,
    input  logic                       ARESETN,
    input  logic                       NEW_IMAGE,
    output logic [IMAGE_SIZE_BITS-1:0] PIX_ADDR,
    input  logic [PIXEL_BITS-1:0]      PIX_DATA,
    output logic [PIXEL_BITS-1:0]      CORE_PIXEL,
    output logic [IMAGE_SIZE_BITS-1:0] CORE_PIXEL_IDX,
    output logic                       CORE_PIXEL_VALID,
    input  logic                       CORE_PIXEL_READY,
    output logic                       CORE_START,
    input  logic                       CORE_DONE,
    input  logic [7:0]                 CORE_DIGIT,
    output logic                       COPROCESSOR_RDY,
    output logic [7:0]                 INFERED_DIGIT,
    output logic                       TIMEOUT,
    output logic                       BUSY
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_LOAD  = 2'd1,
        S_START = 2'd2,
        S_RUN   = 2'd3
    } state_t;

    localparam logic [IMAGE_SIZE_BITS-1:0] LAST_IDX  = IMAGE_SIZE_BITS'(IMAGE_SIZE - 1);
    localparam logic [TIMER_BITS-1:0]      LAST_TICK = TIMER_BITS'(TIMEOUT_CYCLES - 1);

    state_t                       state;
    logic [IMAGE_SIZE_BITS-1:0]   pixel_idx;
    logic [TIMER_BITS-1:0]        timer;
    logic                         pending;
    logic                         new_image_q;
    logic                         core_start_q;
    logic                         rdy_q;
    logic [7:0]                   digit_q;
    logic                         timeout_q;
    logic                         req;

    // A level held high yields exactly one request.
    assign req = NEW_IMAGE & ~new_image_q;

    always_ff @(posedge ACLK) begin
        if (!ARESETN) begin
            state        <= S_IDLE;
            pixel_idx    <= '0;
            timer        <= '0;
            pending      <= 1'b0;
            new_image_q  <= 1'b0;
            core_start_q <= 1'b0;
            rdy_q        <= 1'b0;
            digit_q      <= 8'h00;
            timeout_q    <= 1'b0;
        end else begin
            new_image_q  <= NEW_IMAGE;
            core_start_q <= 1'b0;

            // Only one request can be queued behind the running inference;
            // later ones collapse into the same pending flag.
            if (req && (state != S_IDLE)) begin
                pending <= 1'b1;
            end

            case (state)
                S_IDLE: begin
                    if (req || pending) begin
                        state     <= S_LOAD;
                        pending   <= 1'b0;
                        pixel_idx <= '0;
                        rdy_q     <= 1'b0;
                    end
                end
                S_LOAD: begin
                    if (CORE_PIXEL_READY) begin
                        if (pixel_idx == LAST_IDX) begin
                            pixel_idx    <= '0;
                            state        <= S_START;
                            // Registered so the pulse lines up with the START cycle.
                            core_start_q <= 1'b1;
                        end else begin
                            pixel_idx <= pixel_idx + IMAGE_SIZE_BITS'(1);
                        end
                    end
                end
                S_START: begin
                    timer <= '0;
                    state <= S_RUN;
                end
                S_RUN: begin
                    // Completion takes priority over a watchdog expiry in the same cycle.
                    if (CORE_DONE) begin
                        digit_q   <= CORE_DIGIT;
                        timeout_q <= 1'b0;
                        rdy_q     <= 1'b1;
                        state     <= S_IDLE;
                    end else if (timer == LAST_TICK) begin
                        digit_q   <= 8'hFF;
                        timeout_q <= 1'b1;
                        rdy_q     <= 1'b1;
                        state     <= S_IDLE;
                    end else begin
                        timer <= timer + TIMER_BITS'(1);
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign PIX_ADDR         = pixel_idx;
    assign CORE_PIXEL_IDX   = pixel_idx;
    assign CORE_PIXEL       = PIX_DATA;
    assign CORE_PIXEL_VALID = (state == S_LOAD);
    assign CORE_START       = core_start_q;
    assign COPROCESSOR_RDY  = rdy_q;
    assign INFERED_DIGIT    = digit_q;
    assign TIMEOUT          = timeout_q;
    assign BUSY             = (state != S_IDLE);

endmodule
